// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and default latencies for the multiply/divide unit
package mdu_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operation request and HI/LO result bundle between pipeline and multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, op, a, b, input busy, hi, lo);
    modport slave(input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_compute.sv
// mdu_compute: combinational product, quotient/remainder and divide-by-zero flag from latched operands
module mdu_compute
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               div_zero
);
    logic             sgn;
    logic [WIDTH-1:0] ma, mb, dv, uq, ur;
    always_comb begin
        sgn      = (op == OP_MULT) || (op == OP_DIV);
        prod     = sgn ? {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}
                       : {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        ma       = (sgn && a[WIDTH-1]) ? -a : a;
        mb       = (sgn && b[WIDTH-1]) ? -b : b;
        div_zero = (b == '0);
        // Divisor forced to 1 on zero so the divider never sees X; result is discarded anyway
        dv       = div_zero ? WIDTH'(1) : mb;
        uq       = ma / dv;
        ur       = ma % dv;
        quot     = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
        rem      = (sgn && a[WIDTH-1]) ? -ur : ur;
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide with HI/LO registers and fixed per-op busy latency
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input logic          clk,
    input logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [2:0]          op_q;
    logic [WIDTH-1:0]    a_q, b_q, hi_q, lo_q, hi_n, lo_n, quot, rem;
    logic [2*WIDTH-1:0]  prod;
    logic                div_zero, accept;
    mdu_compute #(.WIDTH(WIDTH)) u_compute (
        .op(op_q), .a(a_q), .b(b_q), .prod(prod), .quot(quot), .rem(rem), .div_zero(div_zero)
    );
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi_q;
        lo_n    = lo_q;
        accept  = (state == IDLE) && bus.start && !bus.op[2];
        if (state == IDLE) begin
            if (accept) begin
                state_n = BUSY;
                cnt_n   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end
            hi_n = (bus.start && bus.op == OP_MTHI) ? bus.a : hi_q;
            lo_n = (bus.start && bus.op == OP_MTLO) ? bus.a : lo_q;
        end else begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state_n = IDLE;
                if (!op_q[1]) {hi_n, lo_n} = prod;
                else if (!div_zero) {hi_n, lo_n} = {rem, quot};
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
        end
    end
    assign bus.busy = (state == BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed HI/LO results and busy-cycle counts
module tb_mul_div_unit;
    import mdu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int n;
    mul_div_unit_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        go(OP_MULT, 32'd3, 32'd4);
        chk("mid_busy_before", 64'(bus.busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_busy", 64'(bus.busy), 64'd0);
        chk("mid_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_reset_never_written", {31'd0, bus.busy, bus.hi, bus.lo}, 64'd0);

        go(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        chk("mult_cycles", 64'(n), 64'd5);
        chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        go(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        chk("multu_cycles", 64'(n), 64'd5);
        chk("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);

        go(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_cycles", 64'(n), 64'd10);
        chk("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        go(OP_DIVU, 32'd7, 32'd2);
        wait_done(n);
        chk("divu_cycles", 64'(n), 64'd10);
        chk("divu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);

        go(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_done(n);
        chk("div_neg_divisor", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFF2);

        go(OP_MTHI, 32'h1234, 32'd0);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        go(OP_MTLO, 32'h5678, 32'd0);
        chk("mtlo_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
        go(OP_DIV, 32'd100, 32'd0);
        wait_done(n);
        chk("divzero_cycles", 64'(n), 64'd10);
        chk("divzero_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

        go(3'd6, 32'hDEAD_BEEF, 32'd1);
        chk("invalid_busy", 64'(bus.busy), 64'd0);
        chk("invalid_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

        go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("intmin_cycles", 64'(n), 64'd10);
        chk("intmin_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        go(OP_MULT, 32'd5, 32'd6);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.a     = 32'hAA;
        @(posedge clk);
        #1;
        chk("ignored_mtlo_lo", 64'(bus.lo), 64'h8000_0000);
        @(negedge clk);
        bus.op = OP_DIV;
        bus.a  = 32'd9;
        bus.b  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        chk("ignored_remaining_cycles", 64'(n), 64'd3);
        chk("ignored_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_001E);
        @(posedge clk);
        #1;
        chk("ignored_no_queue", {31'd0, bus.busy, bus.hi, bus.lo}, 64'h0000_0000_0000_001E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
